// File: rtl/sm_accum_ctrl_pkg.sv
// Shared types for the sign-magnitude accumulator: operand layout, zero/max
// constants and the sequencer state encoding.
package sm_accum_ctrl_pkg;

  localparam int SM_WIDTH = 16;

  typedef struct packed {
    logic                sign;
    logic [SM_WIDTH-2:0] mag;
  } sm_t;

  localparam sm_t                 SM_ZERO    = '0;
  localparam logic [SM_WIDTH-2:0] SM_MAG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sm_accum_ctrl_add.sv
// Combinational sign-magnitude adder; -0 inputs are treated as +0 and an exact
// cancellation yields +0. carry flags a same-sign magnitude carry-out.
module fixed_point_ADD #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic             a_s, b_s;
  logic [WIDTH-2:0] a_m, b_m, s_m;
  logic             s_s;

  always_comb begin
    a_m   = a[WIDTH-2:0];
    b_m   = b[WIDTH-2:0];
    a_s   = a[WIDTH-1] & (|a_m);
    b_s   = b[WIDTH-1] & (|b_m);
    carry = 1'b0;
    s_m   = '0;
    s_s   = 1'b0;
    if (a_s == b_s) begin
      {carry, s_m} = {1'b0, a_m} + {1'b0, b_m};
      s_s          = a_s;
    end else if (a_m >= b_m) begin
      s_m = a_m - b_m;
      s_s = (a_m == b_m) ? 1'b0 : a_s;
    end else begin
      s_m = b_m - a_m;
      s_s = b_s;
    end
    sum = {s_s, s_m};
  end

endmodule

// File: rtl/sm_accum_ctrl.sv
// Streams len sign-magnitude operands through one shared adder and returns the sum.
// Define SM_ACCUM_SAT_EN to saturate on overflow instead of wrapping.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready are both
// high; in_ready is high only in ACCUM, out_valid only in DONE, and out_data is
// held stable while out_valid is high and out_ready is low.
module sm_accum_ctrl
  import sm_accum_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output state_e           state_dbg
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic [WIDTH-1:0] next_acc;

  localparam logic [WIDTH-2:0] MAG_MAX = '1;

  fixed_point_ADD #(.WIDTH(WIDTH)) u_add (
    .a     (acc_q),
    .b     (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
`ifdef SM_ACCUM_SAT_EN
    next_acc = add_carry ? {add_sum[WIDTH-1], MAG_MAX} : add_sum;
`else
    // Wrap: the adder already dropped the carry and kept the sign.
    next_acc = add_sum;
`endif
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = DONE;
          if (len != '0) begin
            len_d   = len;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = next_acc;
          ovf_d = ovf_q | add_carry;
          cnt_d = cnt_q + CNT_W'(1);
          // Compare before incrementing so len = 2^CNT_W-1 never wraps cnt.
          if (cnt_q == len_q - CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    out_valid = (state_q == DONE);
    busy      = (state_q == ACCUM) || (state_q == DONE);
    overflow  = ovf_q;
    state_dbg = state_q;
    // A -0 accumulator is presented as canonical +0.
    out_data  = (out_valid && (|acc_q[WIDTH-2:0])) ? acc_q : '0;
  end

endmodule

// File: tb/tb_sm_accum_ctrl.sv
// Directed scoreboard bench for sm_accum_ctrl; expectations are hand-computed,
// with the overflow results switching on SM_ACCUM_SAT_EN.
module tb_sm_accum_ctrl;
  import sm_accum_ctrl_pkg::*;

  localparam int W = 16;
  localparam int C = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [C-1:0] len_i = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         overflow;
  state_e       state_dbg;

  logic [W:0]   exp_q[$];
  logic [W-1:0] op_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  sm_accum_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len_i),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // monitor: pops one expected {overflow, sum} per accepted result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {15'd0, overflow, out_data}, 32'hDEAD);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result_data", {16'd0, out_data}, {16'd0, e[W-1:0]});
        check("result_ovf", {31'd0, overflow}, {31'd0, e[W]});
      end
    end
  end

  // driver tasks; all start and end at posedge + 1
  task automatic do_start(input logic [C-1:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len_i = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("result_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input int l, input logic [W-1:0] exp_d, input logic exp_o, input int max_gap);
    exp_q.push_back({exp_o, exp_d});
    do_start(C'(l));
    foreach (op_q[i]) begin
      send(op_q[i]);
      if (max_gap > 0 && i < op_q.size() - 1) gap($urandom_range(0, max_gap));
    end
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    if (l == 0) check("zero_len_in_ready", {31'd0, in_ready}, 32'd0);
    drain();
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {16'd0, out_data}, {16'd0, SM_ZERO});
    check("reset_in_ready_busy", {30'd0, in_ready, busy}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});

    // basic: +5 -3 +2 = +4
    op_q = '{16'h0005, 16'h8003, 16'h0002};
    run(3, 16'h0004, 1'b0, 0);

    // zero length
    op_q = {};
    run(0, 16'h0000, 1'b0, 0);

    // canceling terms, negative zero
    op_q = '{16'h8004, 16'h0004};
    run(2, 16'h0000, 1'b0, 0);
    op_q = '{16'h8000};
    run(1, 16'h0000, 1'b0, 0);
    op_q = '{16'h800A, 16'h0003};
    run(2, 16'h8007, 1'b0, 0);

    // overflow, positive and negative
    op_q = '{16'h7FFF, 16'h0001};
`ifdef SM_ACCUM_SAT_EN
    run(2, 16'h7FFF, 1'b1, 0);
`else
    run(2, 16'h0000, 1'b1, 0);
`endif
    op_q = '{16'hFFFF, 16'h8002};
`ifdef SM_ACCUM_SAT_EN
    run(2, 16'hFFFF, 1'b1, 0);
`else
    run(2, 16'h8001, 1'b1, 0);
`endif
    // overflow cleared by the next start
    op_q = '{16'h0001};
    run(1, 16'h0001, 1'b0, 0);

    // random bubbles: 100 - 30 + 7 - 200 + 50 - 0 = -73
    op_q = '{16'h0064, 16'h801E, 16'h0007, 16'h80C8, 16'h0032, 16'h8000};
    run(6, 16'h8049, 1'b0, 3);

    // backpressure with ignored start in DONE
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 16'h0003});
    do_start(C'(2));
    send(16'h0001);
    send(16'h0002);
    start = 1'b1;
    len_i = C'(5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_data", {16'd0, out_data}, 32'h0003);
      check("bp_state", {30'd0, state_dbg}, {30'd0, DONE});
    end
    out_ready = 1'b1;
    drain();
    op_q = '{16'h0009};
    run(1, 16'h0009, 1'b0, 0);

    // reset mid-operation after 2 of 4 terms
    do_start(C'(4));
    send(16'h0010);
    send(16'h0020);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", {30'd0, state_dbg}, {30'd0, IDLE});
    check("rst_mid_outputs", {16'd0, out_data}, 32'd0);
    check("rst_mid_flags", {28'd0, out_valid, in_ready, busy, overflow}, 32'd0);
    op_q = '{16'h0007};
    run(1, 16'h0007, 1'b0, 0);

    // maximum length: 1023 terms of +1
    op_q = {};
    for (int i = 0; i < 1023; i++) op_q.push_back(16'h0001);
    run(1023, 16'h03FF, 1'b0, 0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
